// File: rtl/freq_track_pkg.sv
// Shared types and widths for the resonance frequency tracker.
package freq_track_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_CALC   = 3'd2,
    S_APPLY  = 3'd3,
    S_SETTLE = 3'd4
  } state_e;

  localparam int PHASE_W      = 16;
  localparam int ERR_W        = 18;
  localparam int MAX_AVG_LOG2 = 4;
  localparam int ACC_W        = PHASE_W + MAX_AVG_LOG2;
  localparam int CNT_W        = MAX_AVG_LOG2 + 1;

endpackage

// File: rtl/freq_step_calc.sv
// Averaged phase error -> lock test and clamped next frequency setpoint.
module freq_step_calc
  import freq_track_pkg::*;
#(
  parameter int FREQ_W     = 16,
  parameter int F_MIN      = 35000,
  parameter int F_MAX      = 45000,
  parameter int GAIN_SHIFT = 2,
  parameter int MAX_STEP   = 200,
  parameter int LOCK_TOL   = 3
) (
  input  logic signed [ERR_W-1:0]  err_i,
  input  logic        [FREQ_W-1:0] freq_i,
  output logic                     in_tol_o,
  output logic        [FREQ_W-1:0] freq_o
);

  localparam int SW = FREQ_W + 2;
  localparam logic signed [SW-1:0] MIN_S = SW'(F_MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(F_MAX);

  logic        [ERR_W-1:0] abs_err;
  logic        [ERR_W-1:0] shr;
  logic        [ERR_W-1:0] mag;
  logic signed [SW-1:0]    cand;

  always_comb begin
    abs_err = err_i[ERR_W-1] ? ERR_W'(-err_i) : ERR_W'(err_i);
    shr     = abs_err >> GAIN_SHIFT;
    in_tol_o = (abs_err <= ERR_W'(LOCK_TOL));
    mag = shr;
    if (shr > ERR_W'(MAX_STEP)) mag = ERR_W'(MAX_STEP);
    else if (shr == '0)         mag = ERR_W'(1);
    // Two spare bits keep the raw sum from wrapping before the clamp
    if (err_i[ERR_W-1]) cand = $signed({2'b00, freq_i}) + $signed(SW'(mag));
    else                cand = $signed({2'b00, freq_i}) - $signed(SW'(mag));
    if (cand < MIN_S)      freq_o = FREQ_W'(F_MIN);
    else if (cand > MAX_S) freq_o = FREQ_W'(F_MAX);
    else                   freq_o = FREQ_W'(cand);
  end

endmodule

// File: rtl/freq_track_ctrl.sv
// Closed-loop resonance tracker: averages phase samples and steps freq_set.
module freq_track_ctrl
  import freq_track_pkg::*;
#(
  parameter int FREQ_W       = 16,
  parameter int F_START      = 40000,
  parameter int F_MIN        = 35000,
  parameter int F_MAX        = 45000,
  parameter int PHASE_TARGET = 0,
  parameter int AVG_LOG2     = 2,
  parameter int GAIN_SHIFT   = 2,
  parameter int MAX_STEP     = 200,
  parameter int LOCK_TOL     = 3,
  parameter int LOCK_CNT     = 4,
  parameter int SETTLE_CYC   = 1000,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_diff,
  input  logic               phase_valid,
  output logic [FREQ_W-1:0]  freq_set,
  output logic               freq_update,
  output logic               locked,
  output logic               lost,
  output logic [2:0]         state_o
);

  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int STW = $clog2(SETTLE_CYC + 1);
  localparam int LW  = $clog2(LOCK_CNT + 1);
  localparam int AVG_N = 1 << AVG_LOG2;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [TW-1:0]     tmo_q, tmo_d;
  logic        [STW-1:0]    set_q, set_d;
  logic        [LW-1:0]     lock_q, lock_d;
  logic signed [ERR_W-1:0]  err_q, err_d;
  logic        [FREQ_W-1:0] freq_q, freq_d;
  logic                     upd_q, upd_d;
  logic                     locked_q, locked_d;
  logic                     lost_q, lost_d;

  logic                     in_tol;
  logic        [FREQ_W-1:0] freq_new;
  logic signed [ACC_W-1:0]  avg;
  logic                     last_smp;
  logic                     tmo_hit;
  logic                     set_done;

  freq_step_calc #(
    .FREQ_W     (FREQ_W),
    .F_MIN      (F_MIN),
    .F_MAX      (F_MAX),
    .GAIN_SHIFT (GAIN_SHIFT),
    .MAX_STEP   (MAX_STEP),
    .LOCK_TOL   (LOCK_TOL)
  ) u_step (
    .err_i    (err_q),
    .freq_i   (freq_q),
    .in_tol_o (in_tol),
    .freq_o   (freq_new)
  );

  assign avg      = acc_q >>> AVG_LOG2;
  assign last_smp = phase_valid && (cnt_q == CNT_W'(AVG_N - 1));
  assign tmo_hit  = !phase_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign set_done = (set_q == STW'(SETTLE_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (!lost_q) state_d = S_SETTLE;
        S_ACCUM: begin
          if (last_smp)     state_d = S_CALC;
          else if (tmo_hit) state_d = S_IDLE;
        end
        S_CALC:   state_d = S_APPLY;
        S_APPLY:  state_d = in_tol ? S_ACCUM : S_SETTLE;
        S_SETTLE: if (set_done) state_d = S_ACCUM;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    set_d    = '0;
    lock_d   = lock_q;
    err_d    = err_q;
    freq_d   = freq_q;
    upd_d    = 1'b0;
    locked_d = locked_q;
    lost_d   = lost_q;
    if (state_q != S_ACCUM) begin
      acc_d = '0;
      cnt_d = '0;
      tmo_d = '0;
    end
    if (!enable) begin
      locked_d = 1'b0;
      lost_d   = 1'b0;
      lock_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          lock_d = '0;
          // Lost stays sticky until enable drops, so no auto-restart
          if (!lost_q) begin
            freq_d = FREQ_W'(F_START);
            upd_d  = 1'b1;
          end
        end
        S_ACCUM: begin
          if (phase_valid) begin
            acc_d = acc_q + ACC_W'($signed(phase_diff));
            cnt_d = cnt_q + CNT_W'(1);
            tmo_d = '0;
          end else if (tmo_hit) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_CALC: err_d = ERR_W'(avg) - ERR_W'(PHASE_TARGET);
        S_APPLY: begin
          if (in_tol) begin
            if (lock_q != LW'(LOCK_CNT)) lock_d = lock_q + LW'(1);
            locked_d = (lock_d >= LW'(LOCK_CNT));
          end else begin
            lock_d   = '0;
            locked_d = 1'b0;
            if (freq_new != freq_q) begin
              freq_d = freq_new;
              upd_d  = 1'b1;
            end
          end
        end
        S_SETTLE: if (!set_done) set_d = set_q + STW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      set_q    <= '0;
      lock_q   <= '0;
      err_q    <= '0;
      freq_q   <= FREQ_W'(F_START);
      upd_q    <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      set_q    <= set_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      freq_q   <= freq_d;
      upd_q    <= upd_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign freq_set    = freq_q;
  assign freq_update = upd_q;
  assign locked      = locked_q;
  assign lost        = lost_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_freq_track_ctrl.sv
// Randomized bench for freq_track_ctrl against an arithmetic tracking model.
module tb_freq_track_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] phase_diff;
  logic        phase_valid;
  logic [15:0] freq_set;
  logic        freq_update;
  logic        locked;
  logic        lost;
  logic [2:0]  state_o;

  int errs   = 0;
  int checks = 0;

  int m_f  = 40000;
  int m_lc = 0;
  int m_lk = 0;
  int m_up = 0;

  always #5 clk = ~clk;

  freq_track_ctrl #(
    .SETTLE_CYC  (10),
    .TIMEOUT_CYC (500)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .phase_diff  (phase_diff),
    .phase_valid (phase_valid),
    .freq_set    (freq_set),
    .freq_update (freq_update),
    .locked      (locked),
    .lost        (lost),
    .state_o     (state_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic void model_avg(input int s[4]);
    int sum, avg, err, a, mag, nf;
    sum = 0;
    foreach (s[i]) sum += s[i];
    avg = sum >>> 2;
    err = avg - 0;
    a   = (err < 0) ? -err : err;
    m_up = 0;
    if (a <= 3) begin
      m_lc = (m_lc >= 4) ? 4 : m_lc + 1;
      m_lk = (m_lc >= 4) ? 1 : 0;
    end else begin
      m_lc = 0;
      m_lk = 0;
      mag = a / 4;
      if (mag > 200) mag = 200;
      if (mag < 1)   mag = 1;
      nf = (err > 0) ? m_f - mag : m_f + mag;
      if (nf < 35000) nf = 35000;
      if (nf > 45000) nf = 45000;
      m_up = (nf != m_f) ? 1 : 0;
      m_f  = nf;
    end
  endfunction

  task automatic wait_accum();
    int n = 0;
    while (state_o != 3'd1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_accum", int'(state_o), 1);
  endtask

  task automatic send(input int p);
    phase_diff  = 16'(p);
    phase_valid = 1'b1;
    tick();
    phase_valid = 1'b0;
  endtask

  task automatic do_avg(input int s[4], input int maxgap, input string tag);
    wait_accum();
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      if (i < 3) repeat ($urandom_range(0, maxgap)) tick();
    end
    model_avg(s);
    tick();
    tick();
    check({tag, "_upd"},    int'(freq_update), m_up);
    check({tag, "_freq"},   int'(freq_set),    m_f);
    check({tag, "_locked"}, int'(locked),      m_lk);
  endtask

  task automatic do_const(input int p, input string tag);
    int s[4];
    foreach (s[i]) s[i] = p;
    do_avg(s, 0, tag);
  endtask

  initial begin
    int s[4];
    int n;
    rst = 1'b1;
    enable = 1'b0;
    phase_valid = 1'b0;
    phase_diff = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_freq",   int'(freq_set),    40000);
    check("rst_upd",    int'(freq_update), 0);
    check("rst_locked", int'(locked),      0);
    check("rst_lost",   int'(lost),        0);
    check("rst_state",  int'(state_o),     0);

    enable = 1'b1;
    tick();
    check("en_upd",   int'(freq_update), 1);
    check("en_freq",  int'(freq_set),    40000);
    check("en_state", int'(state_o),     4);
    tick();
    check("en_pulse", int'(freq_update), 0);

    do_const(40, "p40");
    do_const(-9, "m9");
    do_const(5,  "p5");
    for (int k = 0; k < 4; k++) do_const(2, "p2");
    do_const(50, "p50");

    check("settle_state", int'(state_o), 4);
    send(170);
    do_const(2, "settle_ign");

    for (int k = 0; k < 40; k++) begin
      foreach (s[i]) s[i] = int'($urandom_range(0, 360)) - 180;
      do_avg(s, 3, "rand");
    end

    for (int k = 0; k < 120; k++) do_const(180, "fmin");
    check("fmin_hit", int'(freq_set), 35000);
    for (int k = 0; k < 240; k++) do_const(-180, "fmax");
    check("fmax_hit", int'(freq_set), 45000);

    wait_accum();
    n = 0;
    while (!lost && n < 600) begin
      tick();
      n++;
    end
    check("tmo_lost",   int'(lost), 1);
    check("tmo_cyc",    int'(n >= 499 && n <= 501), 1);
    check("tmo_state",  int'(state_o), 0);
    check("tmo_freq",   int'(freq_set), m_f);
    check("tmo_locked", int'(locked), 0);
    repeat (5) tick();
    check("tmo_hold", int'(state_o), 0);
    enable = 1'b0;
    tick();
    check("dis_lost", int'(lost), 0);
    enable = 1'b1;
    tick();
    m_f = 40000;
    m_lc = 0;
    m_lk = 0;
    check("reen_upd",  int'(freq_update), 1);
    check("reen_freq", int'(freq_set),    m_f);

    do_const(40, "pre_rst");
    wait_accum();
    send(30);
    send(-30);
    rst = 1'b1;
    tick();
    check("mid_rst_freq",   int'(freq_set),    40000);
    check("mid_rst_upd",    int'(freq_update), 0);
    check("mid_rst_locked", int'(locked),      0);
    check("mid_rst_lost",   int'(lost),        0);
    check("mid_rst_state",  int'(state_o),     0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
